// File: rtl/serial_sub_pkg.sv
// Shared state encoding and sizing helper for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width able to hold 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, LSB first, one bit per clock behind a start/done handshake.
// Optional macro SERSUB_SATURATE_EN clamps d to 0 when the final borrow is set.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_d;
  logic             r_bq;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sh_next;
  logic [WIDTH-1:0] w_d_final;
  logic             w_diff;
  logic             w_bout;
  logic             w_last;

  full_subtractor_bit u_fs (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_bq),
    .diff (w_diff),
    .bout (w_bout)
  );

  // Result fills from the MSB side so the last bit lands in position WIDTH-1.
  generate
    if (WIDTH == 1) begin : g_sh_one
      assign w_sh_next = w_diff;
    end else begin : g_sh_multi
      assign w_sh_next = {w_diff, r_sh[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERSUB_SATURATE_EN
  assign w_d_final = w_bout ? '0 : w_sh_next;
`else
  assign w_d_final = w_sh_next;
`endif

  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_d      <= '0;
      r_bq     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_sh     <= '0;
            r_d      <= '0;
            r_bq     <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_sh  <= w_sh_next;
          r_bq  <= w_bout;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_d      <= w_d_final;
            r_borrow <= w_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign d      = r_d;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4 and WIDTH=1 instances).
module tb_serial_subtractor;

`ifdef SERSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset4 = 1'b1, start4 = 1'b0, busy4, done4, borrow4;
  logic [3:0] a4 = '0, b4 = '0, d4;
  logic       reset1 = 1'b1, start1 = 1'b0, busy1, done1, borrow1;
  logic [0:0] a1 = '0, b1 = '0, d1;

  int n_tot = 0, n_pass = 0, n_done4 = 0, n_done1 = 0;
  logic [3:0] qd4[$];
  logic       qb4[$];
  logic [0:0] qd1[$];
  logic       qb1[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .borrow(borrow4)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset1), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .d(d1), .borrow(borrow1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Scoreboard: every done pulse pops and checks the oldest expected result.
  always @(negedge clk) begin
    if (done4) begin
      n_done4++;
      if (qd4.size() == 0) chk("w4 unexpected done", 1, 0);
      else begin
        chk("w4 d", d4, qd4.pop_front());
        chk("w4 borrow", borrow4, qb4.pop_front());
      end
    end
    if (done1) begin
      n_done1++;
      if (qd1.size() == 0) chk("w1 unexpected done", 1, 0);
      else begin
        chk("w1 d", d1, qd1.pop_front());
        chk("w1 borrow", borrow1, qb1.pop_front());
      end
    end
  end

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] ed, input logic eb);
    int lat, nb;
    @(negedge clk);
    a4 = ta; b4 = tb; start4 = 1'b1;
    qd4.push_back((SAT && eb) ? 4'd0 : ed);
    qb4.push_back(eb);
    @(negedge clk);
    start4 = 1'b0; a4 = ~ta; b4 = ~tb;
    lat = 1; nb = 0;
    while (!done4 && lat < 12) begin
      if (busy4) nb++;
      @(negedge clk);
      lat++;
    end
    chk("w4 done latency", lat, 5);
    chk("w4 busy cycles", nb, 4);
    @(negedge clk);
    chk("w4 idle after done", {busy4, done4}, 0);
  endtask

  task automatic op1(input logic ta, input logic tb, input logic ed, input logic eb);
    int lat;
    @(negedge clk);
    a1 = ta; b1 = tb; start1 = 1'b1;
    qd1.push_back((SAT && eb) ? 1'b0 : ed);
    qb1.push_back(eb);
    @(negedge clk);
    start1 = 1'b0; a1 = ~ta; b1 = ~tb;
    chk("w1 busy cycle1", busy1, 1);
    lat = 1;
    while (!done1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("w1 done latency", lat, 2);
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[7];
    int base, c;
    tbl = '{'{4'd5, 4'd3, 4'd2, 1'b0}, '{4'd3, 4'd5, 4'd14, 1'b1},
            '{4'd0, 4'd0, 4'd0, 1'b0}, '{4'd15, 4'd15, 4'd0, 1'b0},
            '{4'd0, 4'd15, 4'd1, 1'b1}, '{4'd12, 4'd7, 4'd5, 1'b0},
            '{4'd1, 4'd2, 4'd15, 1'b1}};

    repeat (2) @(negedge clk);
    reset4 = 1'b0; reset1 = 1'b0;
    @(negedge clk);
    chk("w4 reset busy/done", {busy4, done4}, 0);
    chk("w4 reset d/borrow", {d4, borrow4}, 0);
    chk("w1 reset outputs", {busy1, done1, d1, borrow1}, 0);

    foreach (tbl[i]) op4(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo);

    // start during RUN is ignored
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd2; start4 = 1'b1;
    qd4.push_back(4'd5); qb4.push_back(1'b0);
    base = n_done4;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); a4 = 4'd9; b4 = 4'd1; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignored start done count", n_done4 - base, 1);
    chk("ignored start busy", busy4, 0);

    // start held high restarts on the first IDLE cycle after DONE
    @(negedge clk);
    a4 = 4'd6; b4 = 4'd1; start4 = 1'b1;
    repeat (2) begin qd4.push_back(4'd5); qb4.push_back(1'b0); end
    c = 0;
    while (!done4 && c < 20) begin @(negedge clk); c++; end
    c = 0;
    @(negedge clk);
    while (!done4 && c < 20) begin @(negedge clk); c++; end
    chk("held start restart gap", c + 1, 6);
    start4 = 1'b0;
    repeat (2) @(negedge clk);

    // reset in RUN cycle 2, with start asserted on the same edge
    @(negedge clk);
    a4 = 4'd13; b4 = 4'd2; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); reset4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    chk("mid reset busy/done", {busy4, done4}, 0);
    chk("mid reset d/borrow", {d4, borrow4}, 0);
    reset4 = 1'b0; start4 = 1'b0;
    base = n_done4;
    repeat (6) @(negedge clk);
    chk("mid reset no done", n_done4 - base, 0);
    op4(4'd8, 4'd1, 4'd7, 1'b0);

    op1(1'b0, 1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b1, 1'b0, 1'b0);
    op1(1'b1, 1'b0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("w4 scoreboard drained", qd4.size(), 0);
    chk("w1 scoreboard drained", qd1.size(), 0);
    chk("w1 done count", n_done1, 3);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
